// File: rtl/fbuf_pkg.sv
// Shared constants and helpers for the framebuffer write-port arbitration blocks.
package fbuf_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Ceiling log2, usable in parameter context; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(value))) begin
            r++;
        end
        return r;
    endfunction

    // Low bit of channel ch inside a bus packing width-bit fields per channel.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

    // High bit of channel ch inside the same packed bus.
    function automatic int unsigned slice_hi(input int unsigned ch, input int unsigned width);
        return (ch * width) + width - 1;
    endfunction

endpackage

// File: rtl/fbuf_rr_picker.sv
// Combinational request picker: lowest set index, or first set index at/after ptr cyclically.
module fbuf_rr_picker
    import fbuf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDW    = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDW-1:0]    ptr,
    input  logic              mode,
    output logic [IDW-1:0]    winner,
    output logic              any_req
);

    logic found;

    always_comb begin
        winner  = '0;
        found   = 1'b0;
        any_req = |req;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            // mode=1 rotates the search origin to ptr; mode=0 always starts at 0
            if (!found && req[((mode ? 32'(ptr) : 32'd0) + k) % NUM_CH]) begin
                winner = IDW'(((mode ? 32'(ptr) : 32'd0) + k) % NUM_CH);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fbuf_write_arbiter.sv
// N-channel burst-bounded write arbiter driving one registered framebuffer BRAM write port.
module fbuf_write_arbiter
    import fbuf_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned FBUF_ADDR_WIDTH = 19,
    parameter int unsigned FBUF_DATA_WIDTH = 8,
    parameter int unsigned FBUF_WE_WIDTH   = 1,
    parameter int unsigned ARB_MODE        = 1,
    parameter int unsigned MAX_BURST       = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   ch_valid,
    output logic [NUM_CH-1:0]                   ch_ready,
    input  logic [NUM_CH*FBUF_WE_WIDTH-1:0]     ch_wrea,
    input  logic [NUM_CH*FBUF_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*FBUF_DATA_WIDTH-1:0]   ch_data,
    output logic                                fbuf_en_wr,
    output logic [FBUF_WE_WIDTH-1:0]            fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0]          fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0]          fbuf_data,
    output logic [clog2(NUM_CH)-1:0]            grant_id,
    output logic                                grant_active
);

    localparam int unsigned IDW  = clog2(NUM_CH);
    localparam int unsigned CNTW = clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                     state, state_n;
    logic [IDW-1:0]             ptr, ptr_n;
    logic [IDW-1:0]             grant_id_n;
    logic                       grant_active_n;
    logic [CNTW-1:0]            burst_cnt, burst_cnt_n;
    logic                       en_n;
    logic [FBUF_WE_WIDTH-1:0]   wrea_n;
    logic [FBUF_ADDR_WIDTH-1:0] addr_n;
    logic [FBUF_DATA_WIDTH-1:0] data_n;
    logic [IDW-1:0]             winner;
    logic                       any_req;
    logic                       xfer;

    fbuf_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDW    (IDW)
    ) u_picker (
        .req     (ch_valid),
        .ptr     (ptr),
        .mode    (ARB_MODE == ARB_RR),
        .winner  (winner),
        .any_req (any_req)
    );

    // Ready depends only on registered ownership, forced low during reset.
    always_comb begin
        ch_ready = '0;
        if ((state == GRANT) && !rst) begin
            ch_ready[grant_id] = 1'b1;
        end
    end

    assign xfer = (state == GRANT) && ch_valid[grant_id];

    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        grant_id_n     = grant_id;
        grant_active_n = grant_active;
        burst_cnt_n    = burst_cnt;
        en_n           = 1'b0;
        wrea_n         = '0;
        addr_n         = fbuf_addr;
        data_n         = fbuf_data;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n        = GRANT;
                    grant_id_n     = winner;
                    grant_active_n = 1'b1;
                    burst_cnt_n    = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    en_n        = 1'b1;
                    wrea_n      = ch_wrea[slice_lo(32'(grant_id), FBUF_WE_WIDTH) +: FBUF_WE_WIDTH];
                    addr_n      = ch_addr[slice_lo(32'(grant_id), FBUF_ADDR_WIDTH) +: FBUF_ADDR_WIDTH];
                    data_n      = ch_data[slice_lo(32'(grant_id), FBUF_DATA_WIDTH) +: FBUF_DATA_WIDTH];
                    burst_cnt_n = burst_cnt + CNTW'(1);
                end
                // Release on an idle owner or after the last allowed write; one bubble follows.
                if (!xfer || (burst_cnt == CNTW'(MAX_BURST - 1))) begin
                    state_n        = IDLE;
                    grant_active_n = 1'b0;
                    ptr_n          = IDW'((32'(grant_id) + 32'd1) % NUM_CH);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            burst_cnt    <= '0;
            fbuf_en_wr   <= 1'b0;
            fbuf_wrea    <= '0;
            fbuf_addr    <= '0;
            fbuf_data    <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            grant_id     <= grant_id_n;
            grant_active <= grant_active_n;
            burst_cnt    <= burst_cnt_n;
            fbuf_en_wr   <= en_n;
            fbuf_wrea    <= wrea_n;
            fbuf_addr    <= addr_n;
            fbuf_data    <= data_n;
        end
    end

endmodule

// File: doc/fbuf_write_arbiter.md
Name: fbuf_write_arbiter

Overview:
- N-channel write arbiter for the framebuffer BRAM write port.
- Successor to the two-input select-driven framebuffer mux: channels raise requests, the block grants one channel at a time with fixed-priority or round-robin selection, and holds the grant for bounded bursts.
- Drives one registered BRAM write port and reports which channel owns it.

Parameters:
- NUM_CH, 4: number of writer channels, 2..8.
- FBUF_ADDR_WIDTH, 19: BRAM address width.
- FBUF_DATA_WIDTH, 8: BRAM data width.
- FBUF_WE_WIDTH, 1: width of the BRAM write-enable (wrea).
- ARB_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- MAX_BURST, 16: maximum accepted writes per grant, at least 1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- ch_valid  in  NUM_CH  per-channel write request.
- ch_ready  out  NUM_CH  per-channel accept; a write transfers when valid and ready are both 1.
- ch_wrea  in  NUM_CH*FBUF_WE_WIDTH  write enables; channel i occupies slice [i*W +: W].
- ch_addr  in  NUM_CH*FBUF_ADDR_WIDTH  write addresses, packed the same way.
- ch_data  in  NUM_CH*FBUF_DATA_WIDTH  write data, packed the same way.
- fbuf_en_wr  out  1  BRAM port enable.
- fbuf_wrea  out  FBUF_WE_WIDTH  BRAM write enable.
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address.
- fbuf_data  out  FBUF_DATA_WIDTH  BRAM data.
- grant_id  out  clog2(NUM_CH)  current owner; valid while grant_active.
- grant_active  out  1  a channel currently holds the port.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state IDLE;
  - fbuf_en_wr=0, fbuf_wrea=0, fbuf_addr=0, fbuf_data=0;
  - grant_id=0, grant_active=0;
  - round-robin pointer 0, burst counter 0.
- While reset is asserted, ch_ready is forced to 0.
- A reset during a burst drops the grant in that same cycle.
- No partially accepted write is ever emitted after reset.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any ch_valid is set, select a winner and go to GRANT next cycle with grant_id=winner, grant_active=1 and the burst counter cleared.
  - All ch_ready are 0 in IDLE.
- Winner selection:
  - ARB_MODE=0: the lowest set index.
  - ARB_MODE=1: the first set index at or after the pointer, searching cyclically.
- GRANT:
  - ch_ready[grant_id]=1; all other ch_ready are 0.
  - ch_ready is a combinational function of registered state only; it does not depend on ch_valid.
  - On each transfer the burst counter increments.
- Output path:
  - A transfer in cycle t registers the owner's wrea, addr and data onto fbuf_* at edge t+1, with fbuf_en_wr=1 for exactly one cycle.
  - Latency is 1 cycle, and back-to-back transfers give back-to-back writes.
  - In cycles with no transfer, fbuf_en_wr=0 and fbuf_wrea=0; fbuf_addr and fbuf_data hold their last values.
- The burst ends (state goes to IDLE next cycle, grant_active=0) when either:
  - the owner's ch_valid is 0 in GRANT (no transfer that cycle); or
  - a transfer happens with the burst counter at MAX_BURST-1 (the last write is accepted, then the grant is released).
- On every burst end the round-robin pointer becomes (grant_id+1) mod NUM_CH.
- Each burst end therefore costs one IDLE bubble cycle. This is intentional: it bounds any channel's wait to (NUM_CH-1)*(MAX_BURST+1)+1 cycles in round-robin mode.
- If a non-owner raises ch_valid during GRANT, it waits; it is not accepted.
- If several channels request in the same IDLE cycle, arbitration is purely by mode and pointer.
- With MAX_BURST=1 and ARB_MODE=1, channels strictly alternate writes.
- Channels must hold wrea, addr and data stable while valid is high and ready is low.
- Burst counter width is clog2(MAX_BURST+1); it never wraps past MAX_BURST.

Decomposition:
- Package fbuf_pkg holds:
  - ARB_FIXED=0 and ARB_RR=1 constants;
  - the clog2 helper;
  - slice-index helper functions for packed channel buses.
- Sub-module fbuf_rr_picker: combinational, takes req[NUM_CH], ptr and mode, returns winner index and any_req. Reused by later display-side arbiters.
- The FSM, burst counter and output register stay in fbuf_write_arbiter.

Test Plan:
- Reset mid-burst: ch0 streaming, rst asserted for 1 cycle -> the next cycle has fbuf_en_wr=0, grant_active=0, all ch_ready=0; after release, ch0 is re-granted 1 cycle later.
- Single channel: ch2 valid with addr 0x00010..0x00013 and data 0xA0..0xA3 -> grant_id=2 one cycle after valid, fbuf_en_wr high 4 consecutive cycles with matching addr and data, each 1 cycle after its transfer.
- Round-robin fairness: NUM_CH=4, MAX_BURST=2, all valid continuously -> grant order 0,1,2,3,0; exactly 2 writes per grant; 1 bubble between grants.
- Fixed priority: ARB_MODE=0, ch1 and ch3 always valid, MAX_BURST=4 -> ch1 re-wins every arbitration; ch3 is never granted.
- Early release: the owner drops valid after 3 of 16 writes -> 3 writes on fbuf, grant_active falls the next cycle, and the pointer advances to owner+1.
- Hold-stable check: ch0 and ch1 valid, ch1 not granted and holding addr 0x7FFFF -> no write to 0x7FFFF until ch1 owns the port; then exactly one write.
